// File: rtl/cpu_pkg.sv
// Shared CPU pipeline-control types: control ops, exception codes,
// control-register addresses and the pipe_ctrl FSM state.
package cpu_pkg;

  localparam int unsigned PC_W    = 30;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CREG_AW = 5;
  localparam int unsigned IRQ_W   = 8;
  localparam int unsigned EXP_W   = 3;

  typedef enum logic [1:0] {
    CTRL_NOP  = 2'd0,
    CTRL_WRCR = 2'd1,
    CTRL_EXRT = 2'd2
  } ctrl_op_e;

  typedef enum logic [EXP_W-1:0] {
    EXP_NONE = 3'd0,
    EXP_INT  = 3'd1,
    EXP_PRIV = 3'd2
  } exp_code_e;

  localparam logic [CREG_AW-1:0] CREG_STATUS     = 5'd0;
  localparam logic [CREG_AW-1:0] CREG_PRE_STATUS = 5'd1;
  localparam logic [CREG_AW-1:0] CREG_EPC        = 5'd2;
  localparam logic [CREG_AW-1:0] CREG_EXP_VECTOR = 5'd3;
  localparam logic [CREG_AW-1:0] CREG_CAUSE      = 5'd4;
  localparam logic [CREG_AW-1:0] CREG_INT_MASK   = 5'd5;

  typedef struct packed {
    logic int_en;
    logic exe_mode;
  } status_t;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } pipe_ctrl_state_t;

endpackage

// File: rtl/creg_file.sv
// Control register file with combinational read, WRCR writes and trap/EXRT updates.
// INT_MASK exists only when PIPE_CTRL_IRQ_EN is defined; otherwise it reads 0.
module creg_file
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [CREG_AW-1:0] rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [CREG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               trap_en,
  input  logic [EXP_W-1:0]   trap_code,
  input  logic [PC_W-1:0]    trap_pc,
  input  logic               exrt_en,
  output status_t            status,
  output logic [PC_W-1:0]    epc,
  output logic [PC_W-1:0]    exp_vector,
  output logic [IRQ_W-1:0]   int_mask
);

  status_t          pre_status;
  logic [EXP_W-1:0] cause;

  // Trap beats EXRT beats WRCR; the controller never raises two at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status     <= '0;
      pre_status <= '0;
      epc        <= '0;
      exp_vector <= '0;
      cause      <= '0;
    end else if (trap_en) begin
      epc        <= trap_pc;
      pre_status <= status;
      status     <= '0;
      cause      <= trap_code;
    end else if (exrt_en) begin
      status <= pre_status;
    end else if (wr_en) begin
      case (wr_addr)
        CREG_STATUS:     status     <= status_t'(wr_data[1:0]);
        CREG_PRE_STATUS: pre_status <= status_t'(wr_data[1:0]);
        CREG_EPC:        epc        <= wr_data[PC_W-1:0];
        CREG_EXP_VECTOR: exp_vector <= wr_data[PC_W-1:0];
        CREG_CAUSE:      cause      <= wr_data[EXP_W-1:0];
        default: ;
      endcase
    end
  end

`ifdef PIPE_CTRL_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_mask <= 8'hFF;
    end else if (wr_en && !trap_en && !exrt_en && (wr_addr == CREG_INT_MASK)) begin
      int_mask <= wr_data[IRQ_W-1:0];
    end
  end
`else
  assign int_mask = '0;
`endif

  logic unused_wr_bits;
  assign unused_wr_bits = ^wr_data[DATA_W-1:PC_W];

  // No write bypass: reads always see the pre-edge register contents.
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      CREG_STATUS:     rd_data = DATA_W'(status);
      CREG_PRE_STATUS: rd_data = DATA_W'(pre_status);
      CREG_EPC:        rd_data = DATA_W'(epc);
      CREG_EXP_VECTOR: rd_data = DATA_W'(exp_vector);
      CREG_CAUSE:      rd_data = DATA_W'(cause);
      CREG_INT_MASK:   rd_data = DATA_W'(int_mask);
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall/flush generation, trap/EXRT FSM and new_pc select.
// Interrupt support is enabled by defining PIPE_CTRL_IRQ_EN.
module pipe_ctrl
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               if_busy,
  input  logic               mem_busy,
  input  logic               ld_hazard,
  input  logic               mem_en,
  input  logic [PC_W-1:0]    mem_pc,
  input  logic [1:0]         mem_ctrl_op,
  input  logic [EXP_W-1:0]   mem_exp_code,
  input  logic [CREG_AW-1:0] mem_dst_addr,
  input  logic [DATA_W-1:0]  mem_wr_data,
  input  logic [CREG_AW-1:0] creg_rd_addr,
  input  logic [IRQ_W-1:0]   irq,
  output logic [DATA_W-1:0]  creg_rd_data,
  output logic               exe_mode,
  output logic               int_detect,
  output logic [PC_W-1:0]    new_pc,
  output logic               if_stall,
  output logic               id_stall,
  output logic               ex_stall,
  output logic               mem_stall,
  output logic               if_flush,
  output logic               id_flush,
  output logic               ex_flush,
  output logic               mem_flush
);

  pipe_ctrl_state_t state_q, state_d;
  status_t          status;
  logic [PC_W-1:0]  epc;
  logic [PC_W-1:0]  exp_vector;
  logic [IRQ_W-1:0] int_mask;
  logic             stall;
  logic             flush_all;
  logic             trap_en;
  logic             exrt_en;
  logic             wr_en;
  logic [EXP_W-1:0] trap_code;
  ctrl_op_e         op;

  assign stall    = if_busy | mem_busy;
  assign op       = ctrl_op_e'(mem_ctrl_op);
  assign exe_mode = status.exe_mode;

`ifdef PIPE_CTRL_IRQ_EN
  assign int_detect = status.int_en & (|(irq & ~int_mask));
`else
  assign int_detect = 1'b0;
  logic unused_irq;
  assign unused_irq = ^{irq, int_mask, status.int_en};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Only a non-stalled RUN cycle may act; RECOVER just burns one live cycle.
  always_comb begin
    state_d   = state_q;
    flush_all = 1'b0;
    trap_en   = 1'b0;
    exrt_en   = 1'b0;
    wr_en     = 1'b0;
    trap_code = EXP_NONE;
    new_pc    = '0;
    if (!stall && !rst) begin
      case (state_q)
        ST_RUN: begin
          if (mem_en) begin
            if (mem_exp_code != EXP_NONE) begin
              trap_en   = 1'b1;
              trap_code = mem_exp_code;
            end else if (int_detect) begin
              trap_en   = 1'b1;
              trap_code = EXP_INT;
            end else if (op == CTRL_EXRT) begin
              exrt_en = 1'b1;
            end else if (op == CTRL_WRCR) begin
              if ((mem_dst_addr == CREG_STATUS) && status.exe_mode) begin
                trap_en   = 1'b1;
                trap_code = EXP_PRIV;
              end else begin
                wr_en = 1'b1;
              end
            end
          end
        end
        ST_RECOVER: state_d = ST_RUN;
      endcase
    end
    if (trap_en) begin
      flush_all = 1'b1;
      new_pc    = exp_vector;
      state_d   = ST_RECOVER;
    end else if (exrt_en) begin
      flush_all = 1'b1;
      new_pc    = epc;
      state_d   = ST_RECOVER;
    end
  end

  // A redirect wins over a load-use bubble so the new PC can be fetched.
  assign if_stall  = stall | (ld_hazard & ~flush_all);
  assign id_stall  = stall;
  assign ex_stall  = stall;
  assign mem_stall = stall;
  assign if_flush  = flush_all;
  assign id_flush  = flush_all | (ld_hazard & ~stall & ~rst);
  assign ex_flush  = flush_all;
  assign mem_flush = flush_all;

  creg_file u_creg_file (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (creg_rd_addr),
    .rd_data    (creg_rd_data),
    .wr_en      (wr_en),
    .wr_addr    (mem_dst_addr),
    .wr_data    (mem_wr_data),
    .trap_en    (trap_en),
    .trap_code  (trap_code),
    .trap_pc    (mem_pc),
    .exrt_en    (exrt_en),
    .status     (status),
    .epc        (epc),
    .exp_vector (exp_vector),
    .int_mask   (int_mask)
  );

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk in 1 system clock; rst in 1 async active-high reset.
REQ-002 SHALL have stall inputs: if_busy in 1 IF bus wait; mem_busy in 1 MEM bus wait; ld_hazard in 1 ID load-use hazard.
REQ-003 SHALL have MEM-stage inputs: mem_en in 1 valid; mem_pc in 30 word PC; mem_ctrl_op in 2 (NOP/WRCR/EXRT); mem_exp_code in 3 (0 = none); mem_dst_addr in 5 creg write address; mem_wr_data in 32 creg write data.
REQ-004 SHALL have creg read inputs: creg_rd_addr in 5; irq in 8 external interrupt lines.
REQ-005 SHALL have outputs: creg_rd_data out 32; exe_mode out 1 (0 kernel, 1 user); int_detect out 1; new_pc out 30; if_stall, id_stall, ex_stall, mem_stall out 1 each; if_flush, id_flush, ex_flush, mem_flush out 1 each.

Function
REQ-006 SHALL assert all four stall outputs combinationally whenever if_busy or mem_busy is 1 (stall = if_busy|mem_busy).
REQ-007 SHALL, when ld_hazard=1 and stall=0, assert if_stall and id_flush only.
REQ-008 SHALL hold control registers: 0 STATUS{int_en,exe_mode}; 1 PRE_STATUS; 2 EPC (30b); 3 EXP_VECTOR (30b); 4 CAUSE{exp_code}; 5 INT_MASK (8b, 1 = masked). Other addresses SHALL read 0.
REQ-009 SHALL make creg_rd_data a combinational read of creg_rd_addr, zero-extended, with no write bypass.
REQ-010 SHALL make int_detect = STATUS.int_en & |(irq & ~INT_MASK).
REQ-011 SHALL use FSM states RUN and RECOVER.
REQ-012 In RUN with stall=0 and mem_en=1, SHALL take a trap when mem_exp_code!=0 or int_detect=1. Priority: exception, then interrupt (CAUSE = 3'd1), then EXRT, then WRCR.
REQ-013 On a trap cycle SHALL assert all four flush outputs and drive new_pc=EXP_VECTOR in the same cycle.
REQ-014 At the next edge after a trap SHALL set EPC=mem_pc, PRE_STATUS=STATUS, STATUS={0,0}, CAUSE=code, and state=RECOVER.
REQ-015 On EXRT (RUN, stall=0, mem_en=1) SHALL flush all stages and drive new_pc=EPC; at the edge SHALL set STATUS=PRE_STATUS and state=RECOVER.
REQ-016 On WRCR SHALL write mem_wr_data into register mem_dst_addr at the edge. Writes to STATUS in user mode SHALL be ignored and SHALL raise exception code 3'd2 (privilege).
REQ-017 RECOVER SHALL last exactly one non-stalled cycle. In RECOVER, traps and interrupts SHALL be blocked; WRCR and exceptions SHALL be deferred to RUN.
REQ-018 When stall=1, no state, creg or FSM update SHALL occur, and flush outputs SHALL be 0.
REQ-019 When no flush is active, new_pc SHALL be 0.

Reset
REQ-020 rst SHALL asynchronously force: state=RUN, STATUS={0,0} (kernel, int off), PRE_STATUS=0, EPC=0, EXP_VECTOR=0, CAUSE=0, INT_MASK=8'hFF. All flush outputs SHALL be 0.
REQ-021 rst asserted mid-trap SHALL abandon the trap, leaving no partial creg update.

Configuration
REQ-022 With PIPE_CTRL_IRQ_EN defined, interrupts SHALL follow REQ-010.
REQ-023 Without PIPE_CTRL_IRQ_EN: int_detect SHALL be 0, irq SHALL be ignored, INT_MASK SHALL read 0, and writes to INT_MASK SHALL be ignored.

Structure
REQ-024 Shared package cpu_pkg SHALL hold: ctrl_op enum, exp_code enum, creg address constants, pipe_ctrl_state_t.
REQ-025 The register file (REQ-008/009/016) SHALL be a sub-module creg_file. pipe_ctrl SHALL contain the FSM, stall/flush and new_pc logic.

Verification
REQ-026 if_busy=1 for 3 cycles -> all stalls 1 for 3 cycles, no creg change.
REQ-027 mem_en=1, mem_exp_code=3'd4, EXP_VECTOR=30'h100, mem_pc=30'h20 -> same cycle: all flush 1, new_pc=30'h100. Next cycle: EPC=30'h20, CAUSE=4, STATUS=0.
REQ-028 Following REQ-027, EXRT -> new_pc=30'h20 and STATUS restored. An exception in the RECOVER cycle is taken only in the following RUN cycle.
REQ-029 PIPE_CTRL_IRQ_EN, int_en=1, INT_MASK=8'hFE, irq=8'h01 -> int_detect=1, trap with CAUSE=1. Same case with irq=8'h02 -> no trap.
REQ-030 User mode, WRCR to STATUS -> STATUS unchanged, trap CAUSE=2.
REQ-031 ld_hazard=1 with mem_busy=1 -> all stalls 1, id_flush 0.
